// File: rtl/vespa_interrupt_ctrl.sv
// vespa_interrupt_ctrl: interrupt controller for the VeSPA CPU.
// Arbitrates request lines by fixed priority (index 0 highest). It redirects the
// pipeline to a vector with a one-cycle flush/PC-load/interrupt pulse, saves the
// return PC, and reloads that PC when RETI reaches execute.
// Build option: define VESPA_INTC_EDGE_EN for rising-edge, sticky pending bits.
// The default build is level mode, where pending is the registered request lines.
module vespa_interrupt_ctrl #(
    parameter int                   NUM_IRQ       = 4,
    parameter int                   BUS_WIDTH     = 32,
    parameter logic [BUS_WIDTH-1:0] VECTOR_BASE   = 32'h0000_0100,
    parameter int                   VECTOR_STRIDE = 4
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic [NUM_IRQ-1:0]   i_IrqReq,
    input  logic [NUM_IRQ-1:0]   i_IrqMask,
    input  logic                 i_GlobalEn,
    input  logic                 i_Stall,
    input  logic                 i_ExeValid,
    input  logic [BUS_WIDTH-1:0] i_ExePc,
    input  logic                 i_RetiExe,
    output logic                 o_InterruptSignal,
    output logic                 o_Flush,
    output logic                 o_PcLoad,
    output logic [BUS_WIDTH-1:0] o_TargetPc,
    output logic [BUS_WIDTH-1:0] o_ReturnPc,
    output logic                 o_InService,
    output logic [2:0]           o_ActiveId,
    output logic [NUM_IRQ-1:0]   o_Pending
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TAKE    = 2'd1,
        SERVICE = 2'd2,
        RETURN  = 2'd3
    } state_t;

    state_t               state;
    state_t               stateNext;
    logic [NUM_IRQ-1:0]   eligible;
    logic [2:0]           winId;
    logic                 takeEdge;
    logic [BUS_WIDTH-1:0] vectorPc;

    // Priority pick over the enabled pending lines and the take decision.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        eligible = o_Pending & i_IrqMask;
        winId    = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winId = 3'(i);
            end
        end
        takeEdge = (state == IDLE) && (|eligible) && i_GlobalEn && !i_Stall && i_ExeValid;
        vectorPc = VECTOR_BASE + BUS_WIDTH'(VECTOR_STRIDE) * BUS_WIDTH'(winId);
    end

    // Next-state logic; handlers do not nest, so a take only starts from IDLE.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (takeEdge)  stateNext = TAKE;
            TAKE:                   stateNext = SERVICE;
            SERVICE: if (i_RetiExe) stateNext = RETURN;
            RETURN:                 stateNext = IDLE;
            default:                stateNext = IDLE;
        endcase
    end

    // State register plus outputs registered from the next state (no input-to-output path).
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state             <= IDLE;
            o_InterruptSignal <= 1'b0;
            o_Flush           <= 1'b0;
            o_PcLoad          <= 1'b0;
            o_InService       <= 1'b0;
            o_TargetPc        <= '0;
            o_ReturnPc        <= '0;
            o_ActiveId        <= '0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
            state             <= stateNext;
            o_InterruptSignal <= (stateNext == TAKE);
            o_Flush           <= (stateNext == TAKE) || (stateNext == RETURN);
            o_PcLoad          <= (stateNext == TAKE) || (stateNext == RETURN);
            o_InService       <= (stateNext == SERVICE);
            if (takeEdge) begin
                o_ReturnPc <= i_ExePc;
                o_ActiveId <= winId;
                o_TargetPc <= vectorPc;
            end else if (state == SERVICE && i_RetiExe) begin
                o_TargetPc <= o_ReturnPc;
            end
        end
    end

`ifdef VESPA_INTC_EDGE_EN
    logic [NUM_IRQ-1:0] irqPrev;
    logic [NUM_IRQ-1:0] takeClear;

    assign takeClear = takeEdge ? (NUM_IRQ'(1) << winId) : '0;

    // Sticky rising-edge capture; a fresh edge in the clearing cycle wins over the clear.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            irqPrev   <= '0;
            o_Pending <= '0;
        end else begin
            irqPrev   <= i_IrqReq;
            o_Pending <= (o_Pending & ~takeClear) | (i_IrqReq & ~irqPrev);
        end
    end
`else
    // Level mode: pending mirrors the registered request lines.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_Pending <= '0;
        end else begin
            o_Pending <= i_IrqReq;
        end
    end
`endif

endmodule
